// File: rtl/rf_ctrl_pkg.sv
// Shared register-file writeback definitions: default widths, the zero register and the write command.
// Build option RFWB_FIXED_PRIO_EN (see rr_arbiter) selects fixed-priority arbitration.
package rf_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wr_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter for NUM_REQ requesters: round-robin by default, or fixed lowest-index priority
// (no pointer register) when RFWB_FIXED_PRIO_EN is defined. No grants while hold_i is high.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               hold_i,
    input  logic [NUM_REQ-1:0] req_valid_i,
    output logic [NUM_REQ-1:0] grant_o
);

`ifdef RFWB_FIXED_PRIO_EN

    always_comb begin
        grant_o = '0;
        if (!hold_i) begin
            for (int unsigned i = NUM_REQ; i > 0; i--) begin
                if (req_valid_i[i-1]) begin
                    grant_o    = '0;
                    grant_o[i-1] = 1'b1;
                end
            end
        end
    end

`else

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win;
    logic             found;
    int unsigned      idx;

    // Scan NUM_REQ slots starting at the pointer; the first valid slot wins.
    always_comb begin
        grant_o = '0;
        win     = '0;
        found   = 1'b0;
        idx     = 0;
        if (!hold_i) begin
            for (int unsigned off = 0; off < NUM_REQ; off++) begin
                idx = int'(ptr_q) + off;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!found && req_valid_i[idx]) begin
                    found = 1'b1;
                    win   = idx[PTR_W-1:0];
                end
            end
        end
        if (found) grant_o[win] = 1'b1;
        ptr_d = ptr_q;
        if (found) ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NUM_REQ writeback requesters onto the single register-file write port with a
// registered output stage, pending-write mask and contention counter. Option: RFWB_FIXED_PRIO_EN.
module regfile_wb_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = REG_ADDR_W,
    parameter int unsigned DATA_W  = REG_DATA_W,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_addr,
    output logic [DATA_W-1:0]         rf_data,
    output logic [2**ADDR_W-1:0]      pending_mask,
    output logic [CNT_W-1:0]          contention
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    logic [NUM_REQ-1:0]   grant;
    logic                 accept;
    cmd_t                 sel;
    logic                 we_d, we_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    data_q;
    logic [2**ADDR_W-1:0] pend_d, pend_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 cnt_inc;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk_i       (clk),
        .rst_ni      (rst),
        .hold_i      (hold),
        .req_valid_i (req_valid),
        .grant_o     (grant)
    );

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel.addr = req_addr[i*ADDR_W +: ADDR_W];
                sel.data = req_data[i*DATA_W +: DATA_W];
            end
        end
        accept = |grant;
        // Writes to the zero register are consumed but never reach the register file.
        we_d   = accept && (sel.addr != '0);
        pend_d = '0;
        if (we_d) pend_d[sel.addr] = 1'b1;
        cnt_inc = !hold && ($countones(req_valid) >= 2) && (cnt_q != '1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            we_q   <= we_d;
            pend_q <= pend_d;
            if (accept) begin
                addr_q <= sel.addr;
                data_q <= sel.data;
            end
            if (cnt_inc) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign req_ready    = grant;
    assign rf_we        = we_q;
    assign rf_addr      = addr_q;
    assign rf_data      = data_q;
    assign pending_mask = pend_q;
    assign contention   = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against
// a transaction-level reference model; also acts as the register file that receives commits.
module tb_regfile_wb_arbiter;
    import rf_ctrl_pkg::*;

    localparam int N     = 3;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              hold = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic              rf_we;
    logic [AW-1:0]     rf_addr;
    logic [DW-1:0]     rf_data;
    logic [2**AW-1:0]  pending_mask;
    logic [CNT_W-1:0]  contention;

    int checks = 0;
    int errors = 0;

    // Reference model: last accepted command, pointer, contention count
    int          m_ptr = 0;
    bit          m_we = 0;
    wr_cmd_t     m_cmd = '0;
    int          m_cnt = 0;
    logic [DW-1:0] dut_rf [NUM_REGS];

    regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rf_we        (rf_we),
        .rf_addr      (rf_addr),
        .rf_data      (rf_data),
        .pending_mask (pending_mask),
        .contention   (contention)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && rf_we) dut_rf[rf_addr] <= rf_data;
    end

    function automatic int exp_winner();
        if (hold) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_mask();
        int w;
        w = exp_winner();
        return (w < 0) ? '0 : (N'(1) << w);
    endfunction

    function automatic logic [2**AW-1:0] exp_pending();
        logic [2**AW-1:0] p;
        p = '0;
        if (m_we) p[m_cmd.addr] = 1'b1;
        return p;
    endfunction

    task automatic set_req(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_we = 0; m_cmd = '0; m_cnt = 0;
    endtask

    // Advance one clock edge and apply the accepted transfer to the model.
    task automatic step();
        int w;
        w = exp_winner();
        @(posedge clk);
        if (!hold && $countones(req_valid) >= 2 && m_cnt < CMAX) m_cnt++;
        if (w >= 0) begin
            m_cmd.addr = req_addr[w*AW +: AW];
            m_cmd.data = req_data[w*DW +: DW];
            m_we = (m_cmd.addr != REG_ZERO);
`ifndef RFWB_FIXED_PRIO_EN
            m_ptr = (w + 1) % N;
`endif
        end else begin
            m_we = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        hold = 1'b0;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", rf_we); end
        checks++; if (rf_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", rf_addr); end
        checks++; if (rf_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", rf_data); end
        checks++; if (pending_mask !== '0) begin errors++; $display("FAIL reset_pending: got %h want 0", pending_mask); end
        checks++; if (contention !== '0) begin errors++; $display("FAIL reset_contention: got %0d want 0", contention); end
        do_reset();
    endtask

    task automatic test_single();
        set_req(0, 1, 5'd5, 32'hDEADBEEF);
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready: got %b want 001", req_ready); end
        step();
        req_valid[0] = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'hDEADBEEF)
            begin errors++; $display("FAIL single_commit: got we=%b a=%0d d=%h want we=1 a=5 d=deadbeef", rf_we, rf_addr, rf_data); end
        checks++; if (pending_mask !== 32'h20) begin errors++; $display("FAIL single_pending: got %h want 00000020", pending_mask); end
        step();
        checks++; if (rf_we !== 1'b0 || pending_mask !== '0)
            begin errors++; $display("FAIL single_after: got we=%b pm=%h want we=0 pm=0", rf_we, pending_mask); end
    endtask

    task automatic test_round_robin();
        int w;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1, AW'(i + 1), 32'h100 + DW'(i));
        for (int k = 0; k < 6; k++) begin
`ifdef RFWB_FIXED_PRIO_EN
            w = 0;
`else
            w = k % N;
`endif
            #1;
            checks++; if (req_ready !== (N'(1) << w)) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, N'(1) << w); end
            checks++; if (int'(contention) !== k) begin errors++; $display("FAIL rr_contention[%0d]: got %0d want %0d", k, contention, k); end
            step();
            checks++; if (rf_we !== 1'b1 || int'(rf_addr) !== w + 1)
                begin errors++; $display("FAIL rr_commit[%0d]: got we=%b a=%0d want we=1 a=%0d", k, rf_we, rf_addr, w + 1); end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_addr_zero();
        set_req(1, 1, 5'd0, 32'h1234);
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL zero_ready: got %b want 010", req_ready); end
        step();
        req_valid[1] = 1'b0;
        checks++; if (rf_we !== 1'b0 || pending_mask !== '0)
            begin errors++; $display("FAIL zero_commit: got we=%b pm=%h want we=0 pm=0", rf_we, pending_mask); end
        step();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL zero_after: got %b want 0", rf_we); end
    endtask

    task automatic test_same_addr();
        do_reset();
        set_req(0, 1, 5'd8, 32'hA);
        set_req(2, 1, 5'd8, 32'hB);
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL same_first: got %b want 001", req_ready); end
        step();
        req_valid[0] = 1'b0;
        #1;
        checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL same_second: got %b want 100", req_ready); end
        checks++; if (rf_we !== 1'b1 || rf_data !== 32'hA) begin errors++; $display("FAIL same_commitA: got we=%b d=%h want we=1 d=a", rf_we, rf_data); end
        step();
        req_valid[2] = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_data !== 32'hB) begin errors++; $display("FAIL same_commitB: got we=%b d=%h want we=1 d=b", rf_we, rf_data); end
        step();
        checks++; if (dut_rf[8] !== 32'hB) begin errors++; $display("FAIL same_final: got %h want b", dut_rf[8]); end
    endtask

    task automatic test_hold();
        set_req(1, 1, 5'd9, 32'h99);
        step();
        req_valid[1] = 1'b0;
        hold = 1'b1;
        set_req(0, 1, 5'd7, 32'h77);
        #1;
        checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd9) begin errors++; $display("FAIL hold_drain: got we=%b a=%0d want we=1 a=9", rf_we, rf_addr); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (req_ready !== '0) begin errors++; $display("FAIL hold_ready[%0d]: got %b want 000", k, req_ready); end
            step();
            checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL hold_we[%0d]: got %b want 0", k, rf_we); end
        end
        hold = 1'b0;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL hold_release: got %b want 001", req_ready); end
        step();
        req_valid[0] = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd7) begin errors++; $display("FAIL hold_commit: got we=%b a=%0d want we=1 a=7", rf_we, rf_addr); end
    endtask

    task automatic test_reset_mid();
        set_req(0, 1, 5'd4, 32'h4444);
        set_req(1, 1, 5'd3, 32'h3333);
        step();
        req_valid[1] = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (rf_we !== 1'b0 || pending_mask !== '0 || contention !== '0)
            begin errors++; $display("FAIL midrst: got we=%b pm=%h cnt=%0d want all 0", rf_we, pending_mask, contention); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL midrst_regrant: got %b want 001", req_ready); end
        step();
        req_valid[0] = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd4 || rf_data !== 32'h4444)
            begin errors++; $display("FAIL midrst_commit: got we=%b a=%0d d=%h want we=1 a=4 d=4444", rf_we, rf_addr, rf_data); end
    endtask

    task automatic test_random();
        int w;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom % 2 == 0))
                    set_req(i, 1, ($urandom % 4 == 0) ? AW'(8) : AW'($urandom % 32), $urandom);
            end
            hold = ($urandom % 8 == 0);
            #1;
            checks++; if (req_ready !== exp_mask()) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, exp_mask()); end
            checks++; if (rf_we !== m_we) begin errors++; $display("FAIL rand_we[%0d]: got %b want %b", c, rf_we, m_we); end
            if (m_we) begin
                checks++; if (rf_addr !== m_cmd.addr || rf_data !== m_cmd.data)
                    begin errors++; $display("FAIL rand_cmd[%0d]: got a=%0d d=%h want a=%0d d=%h", c, rf_addr, rf_data, m_cmd.addr, m_cmd.data); end
            end
            checks++; if (pending_mask !== exp_pending()) begin errors++; $display("FAIL rand_pending[%0d]: got %h want %h", c, pending_mask, exp_pending()); end
            checks++; if (int'(contention) !== m_cnt) begin errors++; $display("FAIL rand_contention[%0d]: got %0d want %0d", c, contention, m_cnt); end
            w = exp_winner();
            step();
            if (w >= 0) req_valid[w] = 1'b0;
        end
        hold = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_addr_zero();
        test_same_addr();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
